// File: rtl/exe_mul_sequencer_pkg.sv
// Shared types and sizing for the execute-stage multi-cycle multiply sequencer.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

package exe_mul_sequencer_pkg;

    localparam int unsigned DEF_WIDTH          = `ADDRESS_LEN;
    localparam int unsigned DEF_BITS_PER_CYCLE = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int unsigned mul_cycles(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/exe_mul_sequencer_if.sv
// Handshake and operand/result bundle between the EXE stage and the multiply sequencer.
interface exe_mul_sequencer_if #(
    parameter int unsigned WIDTH = exe_mul_sequencer_pkg::DEF_WIDTH
);
    logic             start;
    logic             accumulate;
    logic             S;
    logic             flush;
    logic [WIDTH-1:0] Val_Rm;
    logic [WIDTH-1:0] Val_Rs;
    logic [WIDTH-1:0] Val_Rn;
    logic             C_in;
    logic             V_in;
    logic             freeze;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Mul_Res;
    logic             S_out;
    logic             C_out;
    logic             V_out;
    logic             Z_out;
    logic             N_out;

    modport master (
        output start, accumulate, S, flush, Val_Rm, Val_Rs, Val_Rn, C_in, V_in,
        input  freeze, busy, done, Mul_Res, S_out, C_out, V_out, Z_out, N_out
    );

    modport slave (
        input  start, accumulate, S, flush, Val_Rm, Val_Rs, Val_Rn, C_in, V_in,
        output freeze, busy, done, Mul_Res, S_out, C_out, V_out, Z_out, N_out
    );
endinterface

// File: rtl/exe_mul_sequencer_mul_step.sv
// One shift-add iteration: adds mcand * bits to prod, truncated to WIDTH.
module mul_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BITS  = 2
) (
    input  logic [WIDTH-1:0] i_prod,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [BITS-1:0]  i_bits,
    output logic [WIDTH-1:0] o_prod
);

    logic [WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = i_prod;
        for (int unsigned i = 0; i < BITS; i++) begin
            if (i_bits[i]) begin
                w_sum = w_sum + (i_mcand << i);
            end
        end
        o_prod = w_sum;
    end

endmodule

// File: rtl/exe_mul_sequencer.sv
// Multi-cycle MUL/MLA sequencer with pipeline freeze; result and N/Z/C/V flags for EXE/MEM.
// Optional macro MUL_EARLY_TERMINATE_EN: leave CALC as soon as the remaining multiplier is zero.
module exe_mul_sequencer
    import exe_mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
    input logic                clk,
    input logic                rst,
    exe_mul_sequencer_if.slave bus
);

    localparam int unsigned MUL_CYCLES = mul_cycles(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rn;
    logic               r_acc_f;
    logic               r_s;
    logic               r_c_lat;
    logic               r_v_lat;
    logic [WIDTH-1:0]   r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic               r_n;
    logic               r_z;
    logic               r_c;
    logic               r_v;

    logic               w_accept;
    logic               w_calc_last;
    logic               w_load_res;
    logic [WIDTH-1:0]   w_step_prod;
    logic [WIDTH-1:0]   w_mplier_sh;
    logic [WIDTH-1:0]   w_final;

    mul_step #(
        .WIDTH (WIDTH),
        .BITS  (BITS_PER_CYCLE)
    ) u_mul_step (
        .i_prod  (r_prod),
        .i_mcand (r_mcand),
        .i_bits  (r_mplier[BITS_PER_CYCLE-1:0]),
        .o_prod  (w_step_prod)
    );

    assign w_mplier_sh = r_mplier >> BITS_PER_CYCLE;
    assign w_accept    = bus.start & ~bus.flush & ((r_state == ST_IDLE) | (r_state == ST_DONE));

`ifdef MUL_EARLY_TERMINATE_EN
    assign w_calc_last = (r_cnt == LAST_CNT) | (w_mplier_sh == '0);
`else
    assign w_calc_last = (r_cnt == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // flush overrides every transition; start is only honoured from IDLE or DONE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_CALC;
            ST_CALC: if (w_calc_last) w_next = r_acc_f ? ST_ACC : ST_DONE;
            ST_ACC:  w_next = ST_DONE;
            ST_DONE: w_next = bus.start ? ST_CALC : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (bus.flush) begin
            w_next = ST_IDLE;
        end
    end

    always_comb begin
        bus.freeze = ~bus.flush & ((bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE)))
                                   | (r_state == ST_CALC) | (r_state == ST_ACC));
        bus.busy   = (r_state != ST_IDLE);
        bus.done   = (r_state == ST_DONE) & ~bus.flush;
    end

    assign w_final    = (r_state == ST_ACC) ? (r_prod + r_rn) : w_step_prod;
    assign w_load_res = (w_next == ST_DONE) & ((r_state == ST_CALC) | (r_state == ST_ACC));

    // Result and flags load on the edge into DONE so they are already valid while done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rn     <= '0;
            r_acc_f  <= 1'b0;
            r_s      <= 1'b0;
            r_c_lat  <= 1'b0;
            r_v_lat  <= 1'b0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= bus.Val_Rm;
                r_mplier <= bus.Val_Rs;
                r_rn     <= bus.Val_Rn;
                r_acc_f  <= bus.accumulate;
                r_s      <= bus.S;
                r_c_lat  <= bus.C_in;
                r_v_lat  <= bus.V_in;
                r_prod   <= '0;
                r_cnt    <= '0;
            end else if (r_state == ST_CALC) begin
                r_prod   <= w_step_prod;
                r_mcand  <= r_mcand << BITS_PER_CYCLE;
                r_mplier <= w_mplier_sh;
                r_cnt    <= r_cnt + CNT_W'(1);
            end else if (r_state == ST_ACC) begin
                r_prod   <= w_final;
            end

            if (w_load_res) begin
                r_res <= w_final;
                if (r_s) begin
                    r_n <= w_final[WIDTH-1];
                    r_z <= (w_final == '0);
                    r_c <= r_c_lat;
                    r_v <= r_v_lat;
                end
            end
        end
    end

    assign bus.Mul_Res = r_res;
    assign bus.S_out   = r_s;
    assign bus.N_out   = r_n;
    assign bus.Z_out   = r_z;
    assign bus.C_out   = r_c;
    assign bus.V_out   = r_v;

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Directed self-checking bench for exe_mul_sequencer (WIDTH=32, BITS_PER_CYCLE=2).
`timescale 1ns/1ps
module tb_exe_mul_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exe_mul_sequencer_if #(.WIDTH(32)) bus ();

    exe_mul_sequencer #(
        .WIDTH          (32),
        .BITS_PER_CYCLE (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CALC cycles the sequencer spends on a given multiplier
    function automatic int calc_cycles(input logic [31:0] rs);
`ifdef MUL_EARLY_TERMINATE_EN
        logic [31:0] m;
        int          n;
        m = rs;
        n = 0;
        do begin
            m = m >> 2;
            n++;
        end while ((m != 0) && (n < 16));
        return n;
`else
        return (rs == rs) ? 16 : 16;
`endif
    endfunction

    // Starts an op in the current cycle and ends inside its done cycle (no trailing tick)
    task automatic run_op(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                          input logic [31:0] rn, input logic acc, input logic s,
                          input logic c, input logic v, input logic [31:0] exp_res,
                          input logic en, input logic ez, input logic ec, input logic ev);
        int exp_done;
        exp_done = calc_cycles(rs) + 1 + (acc ? 1 : 0);
        bus.start      = 1'b1;
        bus.Val_Rm     = rm;
        bus.Val_Rs     = rs;
        bus.Val_Rn     = rn;
        bus.accumulate = acc;
        bus.S          = s;
        bus.C_in       = c;
        bus.V_in       = v;
        #2;
        chk({tag, " freeze@0"}, {31'd0, bus.freeze}, 32'd1);
        tick();
        bus.start  = 1'b0;
        bus.Val_Rm = 32'hDEAD_BEEF;
        bus.Val_Rs = 32'hDEAD_BEEF;
        bus.Val_Rn = 32'hDEAD_BEEF;
        bus.C_in   = ~c;
        bus.V_in   = ~v;
        for (int cyc = 1; cyc <= exp_done; cyc++) begin
            #2;
            chk($sformatf("%s freeze@%0d", tag, cyc), {31'd0, bus.freeze}, {31'd0, cyc < exp_done});
            chk($sformatf("%s done@%0d", tag, cyc), {31'd0, bus.done}, {31'd0, cyc == exp_done});
            if (cyc == exp_done) begin
                chk({tag, " Mul_Res"}, bus.Mul_Res, exp_res);
                chk({tag, " N"}, {31'd0, bus.N_out}, {31'd0, en});
                chk({tag, " Z"}, {31'd0, bus.Z_out}, {31'd0, ez});
                chk({tag, " C"}, {31'd0, bus.C_out}, {31'd0, ec});
                chk({tag, " V"}, {31'd0, bus.V_out}, {31'd0, ev});
                chk({tag, " S_out"}, {31'd0, bus.S_out}, {31'd0, s});
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;  bus.accumulate = 1'b0; bus.S = 1'b0; bus.flush = 1'b0;
        bus.Val_Rm = '0;   bus.Val_Rs = '0;       bus.Val_Rn = '0;
        bus.C_in = 1'b0;   bus.V_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset freeze", {31'd0, bus.freeze}, 32'd0);
        chk("reset Mul_Res", bus.Mul_Res, 32'd0);
        chk("reset flags", {27'd0, bus.N_out, bus.Z_out, bus.C_out, bus.V_out, bus.S_out}, 32'd0);
        tick();

        run_op("mul7x6", 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd42, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        #2;
        chk("idle after mul busy", {31'd0, bus.busy}, 32'd0);
        chk("idle after mul Mul_Res held", bus.Mul_Res, 32'd42);
        tick();

        run_op("mla", 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        run_op("trunc", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // S=0 on the first op leaves the flags from the previous op untouched
        run_op("b2b_a", 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12, 1'b0, 1'b1, 1'b1, 1'b1);
        run_op("b2b_b", 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd25, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        bus.start = 1'b1; bus.Val_Rm = 32'd3; bus.Val_Rs = 32'hFFFF_FFFF;
        bus.accumulate = 1'b0; bus.S = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 5; cyc++) tick();
        bus.flush = 1'b1;
        #2;
        chk("flush freeze@5", {31'd0, bus.freeze}, 32'd0);
        chk("flush done@5", {31'd0, bus.done}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #2;
        chk("flush busy@6", {31'd0, bus.busy}, 32'd0);
        chk("flush Mul_Res held", bus.Mul_Res, 32'd25);
        pulses = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        chk("flush no done pulse", pulses, 32'd0);

        run_op("rs_zero", 32'h0000_1234, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        run_op("neg", 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();

        bus.start = 1'b1; bus.Val_Rm = 32'hFFFF_FFFF; bus.Val_Rs = 32'hFFFF_FFFF;
        bus.Val_Rn = 32'd1; bus.accumulate = 1'b1; bus.S = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 9; cyc++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst freeze", {31'd0, bus.freeze}, 32'd0);
        chk("rst Mul_Res", bus.Mul_Res, 32'd0);
        chk("rst flags", {27'd0, bus.N_out, bus.Z_out, bus.C_out, bus.V_out, bus.S_out}, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
